rename_register_file: RTL and testbench



---
 rtl/rename_register_file_if.sv | 38 +++
 rtl/rename_register_file.sv | 92 +++++++++
 tb/tb_rename_register_file.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/rename_register_file_if.sv
// Operand-query and rename/commit bus between the core and the rename register file.
interface rename_register_file_if #(
   parameter int ROB_ID_W = 5,
   parameter int XLEN     = 32
);
   logic                _clear;
   logic                _rf_launch_ready;
   logic [ROB_ID_W-1:0] _rf_launch_rob_id;
   logic [4:0]          _rf_launch_register_id;
   logic                _rf_commit_ready;
   logic [ROB_ID_W-1:0] _rf_commit_rob_id;
   logic [4:0]          _rf_commit_register_id;
   logic [XLEN-1:0]     _rf_commit_value;
   logic [4:0]          _query_reg_1;
   logic [4:0]          _query_reg_2;
   logic                _query_busy_1;
   logic                _query_busy_2;
   logic [ROB_ID_W-1:0] _query_tag_1;
   logic [ROB_ID_W-1:0] _query_tag_2;
   logic [XLEN-1:0]     _query_value_1;
   logic [XLEN-1:0]     _query_value_2;

   modport master (
      output _clear, _rf_launch_ready, _rf_launch_rob_id, _rf_launch_register_id,
             _rf_commit_ready, _rf_commit_rob_id, _rf_commit_register_id, _rf_commit_value,
             _query_reg_1, _query_reg_2,
      input  _query_busy_1, _query_busy_2, _query_tag_1, _query_tag_2,
             _query_value_1, _query_value_2
   );

   modport slave (
      input  _clear, _rf_launch_ready, _rf_launch_rob_id, _rf_launch_register_id,
             _rf_commit_ready, _rf_commit_rob_id, _rf_commit_register_id, _rf_commit_value,
             _query_reg_1, _query_reg_2,
      output _query_busy_1, _query_busy_2, _query_tag_1, _query_tag_2,
             _query_value_1, _query_value_2
   );
endinterface

// File: rtl/rename_register_file.sv
// Architectural register file with per-register rename tags. Launches mark a
// register busy under a ROB tag, commits write values and release the register
// only when the committing tag still owns it. Two combinational operand queries
// forward a same-cycle commit.
module rename_register_file #(
   parameter int ROB_ID_W = 5,
   parameter int XLEN     = 32
) (
   input  logic                   clk_in,
   input  logic                   rst_in,
   input  logic                   rdy_in,
   rename_register_file_if.slave  rf
);
   logic [XLEN-1:0]     regs [0:31];
   logic [ROB_ID_W-1:0] tags [0:31];
   logic [31:0]         busy;

   logic launch_we;
   logic commit_we;
   logic commit_release;
   logic match_1;
   logic match_2;

   // Decode which launch/commit actions are live this cycle.
   always_comb begin
      launch_we      = rdy_in && rf._rf_launch_ready && !rf._clear &&
                       (rf._rf_launch_register_id != 5'd0);
      commit_we      = rdy_in && rf._rf_commit_ready &&
                       (rf._rf_commit_register_id != 5'd0);
      // A younger launch to the same register keeps it busy under the new tag.
      commit_release = commit_we && busy[rf._rf_commit_register_id] &&
                       (tags[rf._rf_commit_register_id] == rf._rf_commit_rob_id) &&
                       !(launch_we && (rf._rf_launch_register_id == rf._rf_commit_register_id));
   end

   // Register values, busy flags and rename tags; clear drops all rename state.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         busy <= 32'd0;
         for (int i = 0; i < 32; i++) begin
            regs[i] <= '0;
            tags[i] <= '0;
         end
      end else if (rdy_in) begin
         if (commit_we) begin
            regs[rf._rf_commit_register_id] <= rf._rf_commit_value;
         end
         if (rf._clear) begin
            busy <= 32'd0;
            for (int i = 0; i < 32; i++) begin
               tags[i] <= '0;
            end
         end else begin
            if (launch_we) begin
               busy[rf._rf_launch_register_id] <= 1'b1;
               tags[rf._rf_launch_register_id] <= rf._rf_launch_rob_id;
            end
            if (commit_release) begin
               busy[rf._rf_commit_register_id] <= 1'b0;
            end
         end
      end
   end

   // Operand queries: pre-launch state, with a same-cycle matching commit forwarded.
   always_comb begin
      match_1 = rdy_in && rf._rf_commit_ready && (rf._query_reg_1 != 5'd0) &&
                (rf._rf_commit_register_id == rf._query_reg_1) &&
                busy[rf._query_reg_1] && (tags[rf._query_reg_1] == rf._rf_commit_rob_id);
      match_2 = rdy_in && rf._rf_commit_ready && (rf._query_reg_2 != 5'd0) &&
                (rf._rf_commit_register_id == rf._query_reg_2) &&
                busy[rf._query_reg_2] && (tags[rf._query_reg_2] == rf._rf_commit_rob_id);
      if (rf._query_reg_1 == 5'd0) begin
         rf._query_busy_1  = 1'b0;
         rf._query_tag_1   = '0;
         rf._query_value_1 = '0;
      end else begin
         rf._query_busy_1  = busy[rf._query_reg_1] && !match_1;
         rf._query_tag_1   = tags[rf._query_reg_1];
         rf._query_value_1 = match_1 ? rf._rf_commit_value : regs[rf._query_reg_1];
      end
      if (rf._query_reg_2 == 5'd0) begin
         rf._query_busy_2  = 1'b0;
         rf._query_tag_2   = '0;
         rf._query_value_2 = '0;
      end else begin
         rf._query_busy_2  = busy[rf._query_reg_2] && !match_2;
         rf._query_tag_2   = tags[rf._query_reg_2];
         rf._query_value_2 = match_2 ? rf._rf_commit_value : regs[rf._query_reg_2];
      end
   end
endmodule

// File: tb/tb_rename_register_file.sv
// Directed table-driven bench for rename_register_file plus hand-written
// sequences for full clear and asynchronous reset.
module tb_rename_register_file;
   logic clk_in;
   logic rst_in;
   logic rdy_in;
   int   compared;
   int   mismatched;

   rename_register_file_if #(.ROB_ID_W(5), .XLEN(32)) bus ();

   rename_register_file #(.ROB_ID_W(5), .XLEN(32)) dut (
      .clk_in (clk_in),
      .rst_in (rst_in),
      .rdy_in (rdy_in),
      .rf     (bus.slave)
   );

   initial clk_in = 1'b0;
   always #5 clk_in = ~clk_in;

   typedef struct {
      logic        rdy;
      logic        lv;
      logic [4:0]  lrd;
      logic [4:0]  lid;
      logic        cv;
      logic [4:0]  crd;
      logic [4:0]  cid;
      logic [31:0] cval;
      logic [4:0]  q1;
      logic [4:0]  q2;
      logic        eb1;
      logic [4:0]  et1;
      logic [31:0] ev1;
      logic        eb2;
      logic [4:0]  et2;
      logic [31:0] ev2;
   } vec_t;

   vec_t vecs [0:17];

   function automatic vec_t mk(input logic rdy, input logic lv, input logic [4:0] lrd,
                               input logic [4:0] lid, input logic cv, input logic [4:0] crd,
                               input logic [4:0] cid, input logic [31:0] cval,
                               input logic [4:0] q1, input logic [4:0] q2,
                               input logic eb1, input logic [4:0] et1, input logic [31:0] ev1,
                               input logic eb2, input logic [4:0] et2, input logic [31:0] ev2);
      vec_t v;
      v.rdy = rdy; v.lv = lv; v.lrd = lrd; v.lid = lid;
      v.cv = cv; v.crd = crd; v.cid = cid; v.cval = cval;
      v.q1 = q1; v.q2 = q2;
      v.eb1 = eb1; v.et1 = et1; v.ev1 = ev1;
      v.eb2 = eb2; v.et2 = et2; v.ev2 = ev2;
      return v;
   endfunction

   task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s[%0d]: got %h, want %h", nm, idx, act, exp);
      end
   endtask

   task automatic idle();
      rdy_in                     = 1'b1;
      bus._clear                 = 1'b0;
      bus._rf_launch_ready       = 1'b0;
      bus._rf_launch_rob_id      = 5'd0;
      bus._rf_launch_register_id = 5'd0;
      bus._rf_commit_ready       = 1'b0;
      bus._rf_commit_rob_id      = 5'd0;
      bus._rf_commit_register_id = 5'd0;
      bus._rf_commit_value       = 32'd0;
   endtask

   task automatic chk_q(input string nm, input int idx,
                        input logic eb1, input logic [4:0] et1, input logic [31:0] ev1,
                        input logic eb2, input logic [4:0] et2, input logic [31:0] ev2);
      chk({nm, "_busy1"},  idx, {31'd0, bus._query_busy_1}, {31'd0, eb1});
      chk({nm, "_tag1"},   idx, {27'd0, bus._query_tag_1},  {27'd0, et1});
      chk({nm, "_value1"}, idx, bus._query_value_1, ev1);
      chk({nm, "_busy2"},  idx, {31'd0, bus._query_busy_2}, {31'd0, eb2});
      chk({nm, "_tag2"},   idx, {27'd0, bus._query_tag_2},  {27'd0, et2});
      chk({nm, "_value2"}, idx, bus._query_value_2, ev2);
   endtask

   initial begin
      compared   = 0;
      mismatched = 0;
      //           rdy  lv    lrd    lid    cv    crd    cid    cval            q1     q2     eb1  et1    ev1             eb2  et2    ev2
      vecs[0]  = mk(1'b1,1'b0,5'd0,5'd0,1'b0,5'd0,5'd0,32'h0,         5'd5,5'd0,1'b0,5'd0,32'h0,         1'b0,5'd0,32'h0);
      vecs[1]  = mk(1'b1,1'b1,5'd3,5'd7,1'b0,5'd0,5'd0,32'h0,         5'd3,5'd0,1'b0,5'd0,32'h0,         1'b0,5'd0,32'h0);
      vecs[2]  = mk(1'b1,1'b0,5'd0,5'd0,1'b0,5'd0,5'd0,32'h0,         5'd3,5'd0,1'b1,5'd7,32'h0,         1'b0,5'd0,32'h0);
      vecs[3]  = mk(1'b1,1'b0,5'd0,5'd0,1'b1,5'd3,5'd7,32'hDEADBEEF,  5'd3,5'd3,1'b0,5'd7,32'hDEADBEEF,  1'b0,5'd7,32'hDEADBEEF);
      vecs[4]  = mk(1'b1,1'b0,5'd0,5'd0,1'b0,5'd0,5'd0,32'h0,         5'd3,5'd4,1'b0,5'd7,32'hDEADBEEF,  1'b0,5'd0,32'h0);
      vecs[5]  = mk(1'b1,1'b1,5'd4,5'd2,1'b0,5'd0,5'd0,32'h0,         5'd4,5'd0,1'b0,5'd0,32'h0,         1'b0,5'd0,32'h0);
      vecs[6]  = mk(1'b1,1'b1,5'd4,5'd9,1'b0,5'd0,5'd0,32'h0,         5'd4,5'd0,1'b1,5'd2,32'h0,         1'b0,5'd0,32'h0);
      vecs[7]  = mk(1'b1,1'b0,5'd0,5'd0,1'b1,5'd4,5'd2,32'h11,        5'd4,5'd3,1'b1,5'd9,32'h0,         1'b0,5'd7,32'hDEADBEEF);
      vecs[8]  = mk(1'b1,1'b0,5'd0,5'd0,1'b1,5'd4,5'd9,32'h22,        5'd4,5'd6,1'b0,5'd9,32'h22,        1'b0,5'd0,32'h0);
      vecs[9]  = mk(1'b1,1'b1,5'd6,5'd1,1'b0,5'd0,5'd0,32'h0,         5'd4,5'd6,1'b0,5'd9,32'h22,        1'b0,5'd0,32'h0);
      vecs[10] = mk(1'b1,1'b1,5'd6,5'd3,1'b1,5'd6,5'd1,32'h55,        5'd6,5'd0,1'b0,5'd1,32'h55,        1'b0,5'd0,32'h0);
      vecs[11] = mk(1'b1,1'b0,5'd0,5'd0,1'b0,5'd0,5'd0,32'h0,         5'd6,5'd4,1'b1,5'd3,32'h55,        1'b0,5'd9,32'h22);
      vecs[12] = mk(1'b1,1'b1,5'd0,5'd5,1'b1,5'd0,5'd0,32'hFFFFFFFF,  5'd0,5'd0,1'b0,5'd0,32'h0,         1'b0,5'd0,32'h0);
      vecs[13] = mk(1'b1,1'b0,5'd0,5'd0,1'b0,5'd0,5'd0,32'h0,         5'd0,5'd6,1'b0,5'd0,32'h0,         1'b1,5'd3,32'h55);
      vecs[14] = mk(1'b0,1'b1,5'd2,5'd5,1'b0,5'd0,5'd0,32'h0,         5'd2,5'd0,1'b0,5'd0,32'h0,         1'b0,5'd0,32'h0);
      vecs[15] = mk(1'b1,1'b0,5'd0,5'd0,1'b0,5'd0,5'd0,32'h0,         5'd2,5'd6,1'b0,5'd0,32'h0,         1'b1,5'd3,32'h55);
      vecs[16] = mk(1'b0,1'b0,5'd0,5'd0,1'b1,5'd6,5'd3,32'h99,        5'd6,5'd4,1'b1,5'd3,32'h55,        1'b0,5'd9,32'h22);
      vecs[17] = mk(1'b1,1'b0,5'd0,5'd0,1'b0,5'd0,5'd0,32'h0,         5'd6,5'd4,1'b1,5'd3,32'h55,        1'b0,5'd9,32'h22);

      idle();
      rst_in = 1'b0;
      bus._query_reg_1 = 5'd5;
      bus._query_reg_2 = 5'd0;
      #12;
      chk_q("reset", 0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
      @(negedge clk_in);
      rst_in = 1'b1;

      // Table: drive at the falling edge, check combinational outputs before the rising edge.
      for (int i = 0; i < 18; i++) begin
         @(negedge clk_in);
         idle();
         rdy_in                     = vecs[i].rdy;
         bus._rf_launch_ready       = vecs[i].lv;
         bus._rf_launch_register_id = vecs[i].lrd;
         bus._rf_launch_rob_id      = vecs[i].lid;
         bus._rf_commit_ready       = vecs[i].cv;
         bus._rf_commit_register_id = vecs[i].crd;
         bus._rf_commit_rob_id      = vecs[i].cid;
         bus._rf_commit_value       = vecs[i].cval;
         bus._query_reg_1           = vecs[i].q1;
         bus._query_reg_2           = vecs[i].q2;
         #1;
         chk_q("vec", i, vecs[i].eb1, vecs[i].et1, vecs[i].ev1,
                         vecs[i].eb2, vecs[i].et2, vecs[i].ev2);
      end

      // Make every register x1..x31 busy with tag equal to its index.
      for (int r = 1; r < 32; r++) begin
         @(negedge clk_in);
         idle();
         bus._rf_launch_ready       = 1'b1;
         bus._rf_launch_register_id = r[4:0];
         bus._rf_launch_rob_id      = r[4:0];
      end
      // Clear with a same-cycle matching commit to x8 and a launch to x9.
      @(negedge clk_in);
      idle();
      bus._clear                 = 1'b1;
      bus._rf_commit_ready       = 1'b1;
      bus._rf_commit_register_id = 5'd8;
      bus._rf_commit_rob_id      = 5'd8;
      bus._rf_commit_value       = 32'h77;
      bus._rf_launch_ready       = 1'b1;
      bus._rf_launch_register_id = 5'd9;
      bus._rf_launch_rob_id      = 5'd4;
      bus._query_reg_1           = 5'd8;
      bus._query_reg_2           = 5'd9;
      #1;
      chk_q("clear_cycle", 0, 1'b0, 5'd8, 32'h77, 1'b1, 5'd9, 32'h0);
      @(negedge clk_in);
      idle();
      for (int r = 1; r < 32; r++) begin
         bus._query_reg_1 = r[4:0];
         bus._query_reg_2 = 5'd8;
         #1;
         chk("after_clear_busy", r, {31'd0, bus._query_busy_1}, 32'd0);
         chk("after_clear_tag",  r, {27'd0, bus._query_tag_1},  32'd0);
      end
      chk("after_clear_x8", 0, bus._query_value_2, 32'h77);

      // Asynchronous reset in the middle of operation.
      @(negedge clk_in);
      idle();
      bus._rf_launch_ready       = 1'b1;
      bus._rf_launch_register_id = 5'd5;
      bus._rf_launch_rob_id      = 5'd3;
      bus._query_reg_1           = 5'd5;
      bus._query_reg_2           = 5'd3;
      @(posedge clk_in);
      #2;
      idle();
      chk_q("pre_reset", 0, 1'b1, 5'd3, 32'h0, 1'b0, 5'd0, 32'hDEADBEEF);
      rst_in = 1'b0;
      #1;
      chk_q("mid_reset", 0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
      @(negedge clk_in);
      rst_in = 1'b1;
      bus._rf_launch_ready       = 1'b1;
      bus._rf_launch_register_id = 5'd5;
      bus._rf_launch_rob_id      = 5'd6;
      @(negedge clk_in);
      idle();
      #1;
      chk_q("post_reset", 0, 1'b1, 5'd6, 32'h0, 1'b0, 5'd0, 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
